tt_um_rps_match_engine: RTL and testbench
=========================================

TT_UM_RPS_MATCH_ENGINE -- requirements
Module: tt_um_rps_match_engine

Interface
REQ-001 SHALL provide parameter ROUNDS_TO_WIN, default 3, round wins needed to take the match (legal range 1..7).
REQ-002 SHALL provide parameter SHOW_CYCLES, default 4, clocks a round result is held before the next commit is accepted (legal range 1..255).
REQ-003 SHALL provide parameter LFSR_SEED, default 8'hA5, reset value of the CPU-move LFSR (must be nonzero).
REQ-004 clk  input  1  single system clock; all state is on its rising edge.
REQ-005 rst_n  input  1  asynchronous, active-low reset.
REQ-006 ena  input  1  design-selected flag; ignored.
REQ-007 ui_in  input  8  [1:0] P1 move, [3:2] P2 move (00 rock, 01 paper, 10 scissors, 11 invalid), [4] commit, [5] mode (0 two-player, 1 P2 is CPU), [6] new_match, [7] unused.
REQ-008 uo_out  output  8  [2:0] P1 score, [5:3] P2 score, [7:6] FSM state code (00 WAIT, 01 EVAL, 10 SHOW, 11 DONE).
REQ-009 uio_in  input  8  unused.
REQ-010 uio_out  output  8  [1:0] last result (00 none, 01 P1 won, 10 P2 won, 11 draw), [3:2] P2 move as evaluated, [4] match_over, [5] match winner (0 P1, 1 P2), [6] invalid, [7] busy.
REQ-011 uio_oe  output  8  constant 8'hFF.

Function
REQ-012 SHALL pass ui_in through a 2-flop synchroniser; all decisions use the synchronised copy.
REQ-013 SHALL detect commit and new_match as rising edges of the synchronised bits (one-cycle pulses).
REQ-014 SHALL implement FSM states WAIT, EVAL, SHOW and DONE.
REQ-015 WAIT: on commit pulse, latch P1 move, and P2 move (ui_in[3:2] in mode 0, CPU move in mode 1); go to EVAL.
REQ-016 EVAL (one cycle): compute result, update scores, last result, P2 move and invalid; go to SHOW, or to DONE if a score reaches ROUNDS_TO_WIN.
REQ-017 Total latency: with moves stable, scores and result SHALL change on the 4th rising clk edge after ui_in[4] rises.
REQ-018 Rules: paper beats rock, scissors beats paper, rock beats scissors; equal moves are a draw with no score change.
REQ-019 Either move = 11: result 00, invalid=1, scores unchanged, go to SHOW; invalid clears on the next EVAL.
REQ-020 SHOW: busy=1, hold for exactly SHOW_CYCLES clocks, then go to WAIT; commit pulses in EVAL or SHOW are dropped, not queued.
REQ-021 DONE: match_over=1, winner valid, busy=0; scores frozen; commit pulses ignored.
REQ-022 new_match pulse in any state: scores, last result, invalid, match_over and winner cleared; go to WAIT on the next edge.
REQ-023 new_match and commit pulses in the same cycle: new_match wins and the commit is discarded.
REQ-024 CPU move: 8-bit Fibonacci LFSR, taps x^8+x^6+x^5+x^4+1, advances every clock in all states; move = lfsr[1:0], with 11 remapped to 00.
REQ-025 Scores are ceil(log2(ROUNDS_TO_WIN+1)) bits, zero-extended to 3 bits, and never exceed ROUNDS_TO_WIN (no wrap).
REQ-026 A mode change takes effect only at the next commit latch.

Reset
REQ-027 rst_n low SHALL immediately force: state WAIT, uo_out=8'h00, uio_out=8'h00, LFSR=LFSR_SEED, synchroniser and edge-detect flops = 0.
REQ-028 rst_n low mid-round (EVAL or SHOW) SHALL abandon the round without a score update.
REQ-029 After reset release, a commit already held high SHALL NOT produce a pulse until ui_in[4] falls and rises again.

Verification
REQ-030 Mode 0, P1=01, P2=00, commit: uo_out[2:0]=1, uio_out[1:0]=01 on the 4th edge; busy=1 for 4 clocks, then state WAIT.
REQ-031 Mode 0, three P2 wins (P1=10, P2=00), defaults: uo_out[5:3]=3, state DONE, uio_out[4]=1, uio_out[5]=1; a further commit leaves all outputs unchanged.
REQ-032 P1=11, P2=01, commit: uio_out[6]=1, uio_out[1:0]=00, scores unchanged; the next valid round clears uio_out[6].
REQ-033 Commit pulse issued during SHOW: dropped, with exactly one score change for two pulses.
REQ-034 new_match and commit rising in the same cycle from a score of 2-1: scores become 0-0, state WAIT, no round evaluated.
REQ-035 Mode 1 after reset: the evaluated P2 move in uio_out[3:2] matches a reference LFSR model seeded 8'hA5 at the latch cycle; uio_oe=8'hFF throughout.

Source files
------------

// File: rtl/tt_um_rps_match_engine.sv
// rtl/tt_um_rps_match_engine.sv - rock-paper-scissors match engine with CPU opponent
module tt_um_rps_match_engine #(
    parameter int         ROUNDS_TO_WIN = 3,
    parameter int         SHOW_CYCLES   = 4,
    parameter logic [7:0] LFSR_SEED     = 8'hA5
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    localparam int            SW        = $clog2(ROUNDS_TO_WIN + 1);
    localparam logic [SW-1:0] WIN       = SW'(ROUNDS_TO_WIN);
    localparam logic [7:0]    SHOW_LAST = 8'(SHOW_CYCLES - 1);

    typedef enum logic [1:0] {
        S_WAIT = 2'b00,
        S_EVAL = 2'b01,
        S_SHOW = 2'b10,
        S_DONE = 2'b11
    } state_t;

    state_t        state;
    logic [7:0]    sync1, sync2;
    logic          commit_q, new_q;
    logic [1:0]    fill;
    logic [1:0]    armed;
    logic [7:0]    lfsr;
    logic [7:0]    show_cnt;
    logic [1:0]    mv1, mv2;
    logic [SW-1:0] p1_score, p2_score;
    logic [1:0]    last_result;
    logic [1:0]    p2_shown;
    logic          invalid, match_over, winner, busy;

    logic          commit_pulse, new_pulse;
    logic [1:0]    cpu_move;
    logic          ev_invalid, ev_draw, ev_p1_wins;
    logic [SW-1:0] p1_next, p2_next;
    logic          unused;

    // Edges only count once the synchroniser has seen the bit low after reset,
    // so a level held across reset release cannot fake a press.
    assign commit_pulse = sync2[4] & ~commit_q & armed[0];
    assign new_pulse    = sync2[6] & ~new_q & armed[1];

    assign cpu_move   = (lfsr[1:0] == 2'b11) ? 2'b00 : lfsr[1:0];
    assign ev_invalid = (mv1 == 2'b11) | (mv2 == 2'b11);
    assign ev_draw    = (mv1 == mv2);
    assign ev_p1_wins = (mv1 == ((mv2 == 2'd2) ? 2'd0 : mv2 + 2'd1));
    assign p1_next    = p1_score + 1'b1;
    assign p2_next    = p2_score + 1'b1;

    assign uo_out  = {state, 3'(p2_score), 3'(p1_score)};
    assign uio_out = {busy, invalid, winner, match_over, p2_shown, last_result};
    assign uio_oe  = 8'hFF;
    assign unused  = &{1'b0, ena, uio_in, sync2[7]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= S_WAIT;
            sync1       <= 8'h00;
            sync2       <= 8'h00;
            commit_q    <= 1'b0;
            new_q       <= 1'b0;
            fill        <= 2'd0;
            armed       <= 2'b00;
            lfsr        <= LFSR_SEED;
            show_cnt    <= 8'h00;
            mv1         <= 2'b00;
            mv2         <= 2'b00;
            p1_score    <= '0;
            p2_score    <= '0;
            last_result <= 2'b00;
            p2_shown    <= 2'b00;
            invalid     <= 1'b0;
            match_over  <= 1'b0;
            winner      <= 1'b0;
            busy        <= 1'b0;
        end else begin
            sync1    <= ui_in;
            sync2    <= sync1;
            commit_q <= sync2[4];
            new_q    <= sync2[6];
            if (fill != 2'd2) begin
                fill <= fill + 2'd1;
            end else begin
                armed <= armed | ~{sync2[6], sync2[4]};
            end
            lfsr <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};

            if (new_pulse) begin
                state       <= S_WAIT;
                p1_score    <= '0;
                p2_score    <= '0;
                last_result <= 2'b00;
                invalid     <= 1'b0;
                match_over  <= 1'b0;
                winner      <= 1'b0;
                busy        <= 1'b0;
                show_cnt    <= 8'h00;
            end else begin
                case (state)
                    S_WAIT: begin
                        if (commit_pulse) begin
                            mv1   <= sync2[1:0];
                            mv2   <= sync2[5] ? cpu_move : sync2[3:2];
                            state <= S_EVAL;
                        end
                    end
                    S_EVAL: begin
                        p2_shown <= mv2;
                        invalid  <= ev_invalid;
                        state    <= S_SHOW;
                        busy     <= 1'b1;
                        show_cnt <= SHOW_LAST;
                        if (ev_invalid) begin
                            last_result <= 2'b00;
                        end else if (ev_draw) begin
                            last_result <= 2'b11;
                        end else if (ev_p1_wins) begin
                            last_result <= 2'b01;
                            p1_score    <= p1_next;
                            if (p1_next == WIN) begin
                                state      <= S_DONE;
                                busy       <= 1'b0;
                                match_over <= 1'b1;
                                winner     <= 1'b0;
                            end
                        end else begin
                            last_result <= 2'b10;
                            p2_score    <= p2_next;
                            if (p2_next == WIN) begin
                                state      <= S_DONE;
                                busy       <= 1'b0;
                                match_over <= 1'b1;
                                winner     <= 1'b1;
                            end
                        end
                    end
                    S_SHOW: begin
                        if (show_cnt == 8'h00) begin
                            state <= S_WAIT;
                            busy  <= 1'b0;
                        end else begin
                            show_cnt <= show_cnt - 8'h01;
                        end
                    end
                    S_DONE: begin
                        state <= S_DONE;
                    end
                    default: state <= S_WAIT;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_tt_um_rps_match_engine.sv
// tb/tb_tt_um_rps_match_engine.sv - directed scoreboard bench for the RPS match engine
module tb_tt_um_rps_match_engine;

    localparam logic [1:0] ST_WAIT = 2'b00;
    localparam logic [1:0] ST_EVAL = 2'b01;
    localparam logic [1:0] ST_SHOW = 2'b10;
    localparam logic [1:0] ST_DONE = 2'b11;

    logic       clk;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uo_out;
    logic [7:0] uio_in;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int checks   = 0;
    int failures = 0;

    logic [15:0] exp_q[$];
    string       tag_q[$];

    logic [1:0] e_st;
    logic [2:0] e_p1, e_p2;
    logic [1:0] e_res, e_p2m;
    logic       e_inv, e_over, e_win, e_busy;

    logic [7:0] m_lfsr;

    tt_um_rps_match_engine dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .ena    (ena),
        .ui_in  (ui_in),
        .uo_out (uo_out),
        .uio_in (uio_in),
        .uio_out(uio_out),
        .uio_oe (uio_oe)
    );

    always #5 clk = ~clk;

    // Reference CPU-move generator: x^8+x^6+x^5+x^4+1, seeded 8'hA5.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 8'hA5;
        else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic logic [1:0] cpu_of(input logic [7:0] l);
        return (l[1:0] == 2'b11) ? 2'b00 : l[1:0];
    endfunction

    function automatic logic beats(input logic [1:0] a, input logic [1:0] b);
        return (a == 2'd1 && b == 2'd0) || (a == 2'd2 && b == 2'd1) || (a == 2'd0 && b == 2'd2);
    endfunction

    task automatic model_clear_all();
        e_st = ST_WAIT; e_p1 = 3'd0; e_p2 = 3'd0; e_res = 2'b00; e_p2m = 2'b00;
        e_inv = 1'b0; e_over = 1'b0; e_win = 1'b0; e_busy = 1'b0;
    endtask

    task automatic push(input string tag);
        exp_q.push_back({e_st, e_p2, e_p1, e_busy, e_inv, e_win, e_over, e_p2m, e_res});
        tag_q.push_back(tag);
    endtask

    task automatic check_next();
        logic [15:0] e;
        string       t;
        e = exp_q.pop_front();
        t = tag_q.pop_front();
        checks++;
        assert (uo_out === e[15:8]) else begin
            failures++;
            $error("FAIL %s uo_out observed=%h expected=%h", t, uo_out, e[15:8]);
        end
        checks++;
        assert (uio_out === e[7:0]) else begin
            failures++;
            $error("FAIL %s uio_out observed=%h expected=%h", t, uio_out, e[7:0]);
        end
        checks++;
        assert (uio_oe === 8'hFF) else begin
            failures++;
            $error("FAIL %s uio_oe observed=%h expected=ff", t, uio_oe);
        end
    endtask

    task automatic do_round(input string tag, input logic [1:0] m1, input logic [1:0] m2,
                            input logic mode);
        logic [1:0] p2m;
        ui_in = {2'b00, mode, 1'b0, m2, m1};
        tick(2);
        ui_in[4] = 1'b1;
        tick(2);
        p2m = mode ? cpu_of(m_lfsr) : m2;
        if (e_st == ST_DONE) begin
            push({tag, "_done_hold"});
            tick(6);
            check_next();
            ui_in[4] = 1'b0;
        end else begin
            e_st = ST_EVAL;
            push({tag, "_latch"});
            tick(1);
            check_next();
            e_p2m = p2m;
            if (m1 == 2'b11 || p2m == 2'b11) begin
                e_res = 2'b00; e_inv = 1'b1;
            end else begin
                e_inv = 1'b0;
                if (m1 == p2m) e_res = 2'b11;
                else if (beats(m1, p2m)) begin e_res = 2'b01; e_p1 = e_p1 + 3'd1; end
                else begin e_res = 2'b10; e_p2 = e_p2 + 3'd1; end
            end
            if (e_p1 == 3'd3) begin
                e_st = ST_DONE; e_over = 1'b1; e_win = 1'b0; e_busy = 1'b0;
            end else if (e_p2 == 3'd3) begin
                e_st = ST_DONE; e_over = 1'b1; e_win = 1'b1; e_busy = 1'b0;
            end else begin
                e_st = ST_SHOW; e_busy = 1'b1;
            end
            push({tag, "_eval"});
            tick(1);
            check_next();
            ui_in[4] = 1'b0;
            if (e_st == ST_SHOW) begin
                push({tag, "_show"});
                tick(3);
                check_next();
                e_st = ST_WAIT; e_busy = 1'b0;
                push({tag, "_wait"});
                tick(1);
                check_next();
            end
        end
    endtask

    initial begin
        clk = 1'b0; rst_n = 1'b0; ena = 1'b1; ui_in = 8'h00; uio_in = 8'h00;
        model_clear_all();

        tick(2);
        push("reset");
        check_next();
        rst_n = 1'b1;
        tick(4);

        do_round("p1_paper", 2'd1, 2'd0, 1'b0);
        do_round("invalid", 2'd3, 2'd1, 1'b0);
        do_round("draw_clears_inv", 2'd0, 2'd0, 1'b0);

        // Second commit rises while the first round is in EVAL/SHOW.
        ui_in = {2'b00, 1'b0, 1'b0, 2'd1, 2'd2};
        tick(2);
        ui_in[4] = 1'b1;
        tick(2);
        ui_in[4] = 1'b0;
        e_st = ST_EVAL;
        push("drop_latch");
        tick(1);
        check_next();
        ui_in = {2'b00, 1'b0, 1'b1, 2'd1, 2'd0};
        e_st = ST_SHOW; e_busy = 1'b1; e_p1 = e_p1 + 3'd1; e_res = 2'b01; e_p2m = 2'd1; e_inv = 1'b0;
        push("drop_eval");
        tick(1);
        check_next();
        push("drop_show");
        tick(3);
        check_next();
        e_st = ST_WAIT; e_busy = 1'b0;
        push("drop_wait");
        tick(1);
        check_next();
        push("drop_no_queue");
        tick(6);
        check_next();
        ui_in = 8'h00;

        do_round("p2_paper", 2'd0, 2'd1, 1'b0);

        // new_match and commit together from 2-1.
        ui_in = 8'h04;
        tick(2);
        ui_in = 8'h54;
        tick(2);
        e_st = ST_WAIT; e_p1 = 3'd0; e_p2 = 3'd0; e_res = 2'b00;
        e_inv = 1'b0; e_over = 1'b0; e_win = 1'b0; e_busy = 1'b0;
        push("newmatch_commit");
        tick(1);
        check_next();
        push("newmatch_no_round");
        tick(5);
        check_next();
        ui_in = 8'h00;

        do_round("p2_win1", 2'd2, 2'd0, 1'b0);
        do_round("p2_win2", 2'd2, 2'd0, 1'b0);
        do_round("p2_win3", 2'd2, 2'd0, 1'b0);
        do_round("done_commit", 2'd1, 2'd0, 1'b0);

        ui_in = 8'h40;
        tick(3);
        e_st = ST_WAIT; e_p1 = 3'd0; e_p2 = 3'd0; e_res = 2'b00;
        e_inv = 1'b0; e_over = 1'b0; e_win = 1'b0; e_busy = 1'b0;
        push("newmatch_from_done");
        check_next();
        ui_in = 8'h00;
        tick(2);

        // Reset in EVAL with commit held through reset release.
        ui_in = {2'b00, 1'b0, 1'b0, 2'd0, 2'd1};
        tick(2);
        ui_in[4] = 1'b1;
        tick(3);
        rst_n = 1'b0;
        #1;
        model_clear_all();
        push("async_reset_mid_round");
        check_next();
        tick(2);
        rst_n = 1'b1;
        push("held_commit_after_reset");
        tick(8);
        check_next();

        do_round("cpu1", 2'd1, 2'd3, 1'b1);
        do_round("cpu2", 2'd2, 2'd3, 1'b1);
        do_round("mode0_after_cpu", 2'd0, 2'd2, 1'b0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
